// File: rtl/tdpram_byte_enable.sv
// True dual-port RAM, one clock, per-byte write enables, selectable read-during-write mode.
// Latency: access sampled at edge N, array updated at N+1, data_out/valid at N+READ_LATENCY.
// Backpressure: none; each port takes one access per cycle and valid is a one-cycle pulse per read.
//
// Ports: clk, reset (synchronous, active-high)
//   per port X in {A,B}: enable_X, write_enable_X (one bit per byte lane), address_X,
//   data_in_X -> data_out_X, valid_X
//   collision (one-cycle pulse), collision_count (saturating at 16'hFFFF)

module tdpram_byte_enable #(
  parameter int    RAM_WIDTH    = 16,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    RAM_DEPTH    = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string RDW_MODE     = "WRITE_FIRST",
  localparam int   NB_COL       = RAM_WIDTH / BYTE_WIDTH,
  localparam int   AW           = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 enable_A,
  input  logic [NB_COL-1:0]    write_enable_A,
  input  logic [AW-1:0]        address_A,
  input  logic [RAM_WIDTH-1:0] data_in_A,
  output logic [RAM_WIDTH-1:0] data_out_A,
  output logic                 valid_A,

  input  logic                 enable_B,
  input  logic [NB_COL-1:0]    write_enable_B,
  input  logic [AW-1:0]        address_B,
  input  logic [RAM_WIDTH-1:0] data_in_B,
  output logic [RAM_WIDTH-1:0] data_out_B,
  output logic                 valid_B,

  output logic                 collision,
  output logic [15:0]          collision_count
);

  localparam bit          MODE_WF = (RDW_MODE == "WRITE_FIRST");
  localparam bit          MODE_NC = (RDW_MODE == "NO_CHANGE");
  localparam logic [31:0] DEPTH_U = 32'(RAM_DEPTH);

  // One registered access per port; the array is touched one edge after sampling.
  typedef struct packed {
    logic                 vld;
    logic [NB_COL-1:0]    we;
    logic [AW-1:0]        addr;
    logic [RAM_WIDTH-1:0] dat;
  } req_t;

  function automatic req_t mk_req(input logic                 en,
                                  input logic [NB_COL-1:0]    we,
                                  input logic [AW-1:0]        addr,
                                  input logic [RAM_WIDTH-1:0] dat);
    req_t r;
    r.vld  = en;
    r.we   = en ? we : '0;
    r.addr = addr;
    r.dat  = dat;
    return r;
  endfunction

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  req_t req_a, req_b;

  // ---------------------------------------------------------------------------
  // Request stage: anything presented while reset is high is simply not captured.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      req_a <= '0;
      req_b <= '0;
    end else begin
      req_a <= mk_req(enable_A, write_enable_A, address_A, data_in_A);
      req_b <= mk_req(enable_B, write_enable_B, address_B, data_in_B);
    end
  end

  // ---------------------------------------------------------------------------
  // Execute stage: array read, lane arbitration, read-during-write return word.
  // ---------------------------------------------------------------------------
  logic                 in_rng_a, in_rng_b;
  logic                 wr_a, wr_b;
  logic                 same_addr;
  logic [NB_COL-1:0]    ovl_mask;   // lanes both ports try to write at one address
  logic [NB_COL-1:0]    lane_a;     // lanes port A actually commits
  logic [NB_COL-1:0]    lane_b;     // lanes port B actually commits (A wins overlaps)
  logic                 coll_hit;
  logic [RAM_WIDTH-1:0] old_a, old_b;
  logic [RAM_WIDTH-1:0] fin_a, fin_b;
  logic [RAM_WIDTH-1:0] ret_a, ret_b;
  logic                 load_a, load_b;

  assign in_rng_a  = 32'(req_a.addr) < DEPTH_U;
  assign in_rng_b  = 32'(req_b.addr) < DEPTH_U;
  assign wr_a      = in_rng_a & (|req_a.we);
  assign wr_b      = in_rng_b & (|req_b.we);
  assign same_addr = (req_a.addr == req_b.addr);
  assign ovl_mask  = (wr_a & wr_b & same_addr) ? (req_a.we & req_b.we) : '0;
  assign coll_hit  = |ovl_mask;
  assign lane_a    = wr_a ? req_a.we : '0;
  assign lane_b    = (wr_b ? req_b.we : '0) & ~ovl_mask;

  // Out-of-range reads see an all-zero word; writes there have no lanes enabled.
  assign old_a = in_rng_a ? mem[req_a.addr] : '0;
  assign old_b = in_rng_b ? mem[req_b.addr] : '0;

  // Final stored word at each port's address, including the other port's lanes
  // when both ports write the same word this cycle.
  always_comb begin
    fin_a = old_a;
    fin_b = old_b;
    for (int i = 0; i < NB_COL; i++) begin
      if (lane_a[i])
        fin_a[i*BYTE_WIDTH +: BYTE_WIDTH] = req_a.dat[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (same_addr && lane_b[i])
        fin_a[i*BYTE_WIDTH +: BYTE_WIDTH] = req_b.dat[i*BYTE_WIDTH +: BYTE_WIDTH];

      if (lane_b[i])
        fin_b[i*BYTE_WIDTH +: BYTE_WIDTH] = req_b.dat[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (same_addr && lane_a[i])
        fin_b[i*BYTE_WIDTH +: BYTE_WIDTH] = req_a.dat[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // A read always returns the pre-write word, so a cross-port write in the same
  // cycle is never visible to it. Own-port writes follow RDW_MODE.
  always_comb begin
    ret_a  = '0;
    load_a = 1'b0;
    if (req_a.vld) begin
      if (|req_a.we) begin
        load_a = !MODE_NC;
        ret_a  = MODE_WF ? fin_a : old_a;
      end else begin
        load_a = 1'b1;
        ret_a  = old_a;
      end
    end
  end

  always_comb begin
    ret_b  = '0;
    load_b = 1'b0;
    if (req_b.vld) begin
      if (|req_b.we) begin
        load_b = !MODE_NC;
        ret_b  = MODE_WF ? fin_b : old_b;
      end else begin
        load_b = 1'b1;
        ret_b  = old_b;
      end
    end
  end

  // Array write. lane_a and lane_b never overlap at one address, so the two
  // ports never drive the same bits in the same cycle. A write accepted before
  // reset still lands if reset rises on its execute edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_COL; i++) begin
      if (lane_a[i])
        mem[req_a.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= req_a.dat[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (lane_b[i])
        mem[req_b.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= req_b.dat[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Array output register. Data only moves on a valid result so that idle
  // cycles and NO_CHANGE writes leave data_out untouched.
  // ---------------------------------------------------------------------------
  logic [RAM_WIDTH-1:0] s1_dat_a, s1_dat_b;
  logic                 s1_vld_a, s1_vld_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_dat_a <= '0;
      s1_dat_b <= '0;
      s1_vld_a <= 1'b0;
      s1_vld_b <= 1'b0;
    end else begin
      s1_vld_a <= load_a;
      s1_vld_b <= load_b;
      if (load_a) s1_dat_a <= ret_a;
      if (load_b) s1_dat_b <= ret_b;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [RAM_WIDTH-1:0] s2_dat_a, s2_dat_b;
      logic                 s2_vld_a, s2_vld_b;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_dat_a <= '0;
          s2_dat_b <= '0;
          s2_vld_a <= 1'b0;
          s2_vld_b <= 1'b0;
        end else begin
          s2_vld_a <= s1_vld_a;
          s2_vld_b <= s1_vld_b;
          if (s1_vld_a) s2_dat_a <= s1_dat_a;
          if (s1_vld_b) s2_dat_b <= s1_dat_b;
        end
      end

      assign data_out_A = s2_dat_a;
      assign data_out_B = s2_dat_b;
      assign valid_A    = s2_vld_a;
      assign valid_B    = s2_vld_b;
    end else begin : g_lat1
      assign data_out_A = s1_dat_a;
      assign data_out_B = s1_dat_b;
      assign valid_A    = s1_vld_a;
      assign valid_B    = s1_vld_b;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Collision flag and saturating counter, both updated on the execute edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      collision       <= 1'b0;
      collision_count <= '0;
    end else begin
      collision <= coll_hit;
      if (coll_hit && (collision_count != 16'hFFFF))
        collision_count <= collision_count + 16'd1;
    end
  end

endmodule
